cb_result_serializer: RTL and testbench
=======================================

// Module: cb_result_serializer
// PURPOSE
//  Downstream stage of the combinational operator block (cb). On a start pulse it
//  snapshots the nine 4-bit operator results in one cycle. It then streams them out
//  one per beat over a valid/ready interface, tagged with an index.
//  Lets a narrow consumer (UART/log FIFO) drain all results while cb inputs keep changing.
// PARAMETERS
//  W      4  width of each result bus and of out_data
//  IDX_W  4  width of out_idx (must hold 0..8)
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous active-low reset
//  start          in   1      capture request; honoured only in IDLE
//  Arithmetic     in   W      result slot 0
//  Shift          in   W      result slot 1
//  Relational     in   W      result slot 2
//  Equality       in   W      result slot 3
//  Bitwise        in   W      result slot 4
//  Reduction      in   W      result slot 5
//  Logical        in   W      result slot 6
//  Concatenation  in   W      result slot 7
//  Conditional    in   W      result slot 8
//  out_valid      out  1      out_data/out_idx/out_last valid
//  out_ready      in   1      consumer accepts beat when out_valid&&out_ready
//  out_data       out  W      current result slot value
//  out_idx        out  IDX_W  slot number 0..8
//  out_last       out  1      high with slot 8
//  busy           out  1      high in SEND
//  done           out  1      one-cycle pulse after slot 8 accepted
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; out_valid, out_idx, out_last, busy, done all 0.
//   - Snapshot regs and out_data are 0.
//  FSM states: IDLE, SEND.
//  IDLE: start=1 at edge k -> all nine inputs latched at edge k; state=SEND; idx=0.
//   - out_valid=1, busy=1 from cycle k+1.
//   - Capture-to-first-valid latency is 1 cycle.
//  SEND: out_valid=1; out_data=snap[idx]; out_last=(idx==8).
//   - Handshake with idx<8 -> idx+1 at next edge.
//   - Handshake with idx==8 -> IDLE, out_valid=0, idx=0, done=1 for exactly one cycle.
//   - out_ready=0 -> out_data/out_idx/out_last held stable; out_valid stays 1.
//     out_valid never drops without a handshake.
//  out_valid does not depend combinationally on out_ready.
//  Input changes after the capture edge never affect streamed data.
//  start while in SEND is ignored: no re-capture, no queuing.
//  start in the done cycle (state is IDLE) is accepted; the next frame begins.
//  Full frame with out_ready held 1: start edge + 9 beats; done in the cycle after beat 8.
//  Reset mid-frame: out_valid drops at that edge, frame is abandoned, no done pulse.
//  idx never exceeds 8. Values are passed through unmodified; no arithmetic is performed.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> out_valid=0, busy=0, done=0, out_idx=0, out_data=0.
//  2 Stream, ready=1:
//    - Inputs = 4'h1..4'h9 (slots 0..8), pulse start.
//    - Expect 9 consecutive beats, data 1..9, idx 0..8.
//    - out_last only on idx 8; done one cycle later; busy=0 after.
//  3 Snapshot isolation:
//    - After the start edge, change every input to 4'hF.
//    - Streamed data must still be 1..9.
//  4 Backpressure:
//    - out_ready=0 for 3 cycles at idx 4.
//    - out_data=4'h5 and idx=4 stable, out_valid=1; resumes at idx 5 when ready=1.
//  5 start during SEND (at idx 2, inputs=4'hA):
//    - Ignored; frame finishes with the original 1..9 and exactly one done.
//  6 Reset at idx 6:
//    - out_valid=0 next cycle, no done.
//    - A new start with inputs 4'hC yields 9 beats of 4'hC starting idx 0.

Source files
------------

// File: rtl/cb_result_serializer_if.sv
// cb_result_serializer_if: valid/ready result stream from the serializer to a narrow consumer
interface cb_result_serializer_if #(
  parameter int W = 4,
  parameter int IDX_W = 4
);
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic out_last;
  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/cb_result_serializer.sv
// cb_result_serializer: snapshots nine cb operator results on start and streams them out one per beat
module cb_result_serializer #(
  parameter int W = 4,
  parameter int IDX_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [W-1:0] Arithmetic,
  input  logic [W-1:0] Shift,
  input  logic [W-1:0] Relational,
  input  logic [W-1:0] Equality,
  input  logic [W-1:0] Bitwise,
  input  logic [W-1:0] Reduction,
  input  logic [W-1:0] Logical,
  input  logic [W-1:0] Concatenation,
  input  logic [W-1:0] Conditional,
  cb_result_serializer_if.master bus,
  output logic busy,
  output logic done
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [W-1:0] snap [0:8];
  logic [IDX_W-1:0] idx;
  logic hs, last, capture;
  assign last = idx == IDX_W'(8);
  assign hs = bus.out_valid && bus.out_ready;
  assign capture = state == IDLE && start;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (start ? SEND : IDLE) : ((hs && last) ? IDLE : SEND);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap <= '{default: '0};
      idx <= '0;
      done <= 1'b0;
    end else begin
      done <= hs && last;
      if (capture) begin
        snap <= '{Arithmetic, Shift, Relational, Equality, Bitwise,
                  Reduction, Logical, Concatenation, Conditional};
        idx <= '0;
      end else if (hs) idx <= last ? '0 : idx + IDX_W'(1);
    end
  end
  assign bus.out_valid = state == SEND;
  assign bus.out_data = snap[idx];
  assign bus.out_idx = idx;
  assign bus.out_last = state == SEND && last;
  assign busy = state == SEND;
endmodule

// File: tb/tb_cb_result_serializer.sv
// tb_cb_result_serializer: table-driven and directed checks of the result serializer
module tb_cb_result_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] res [0:8];
  logic busy, done;
  int checks = 0;
  int errors = 0;

  cb_result_serializer_if #(.W(4), .IDX_W(4)) bus ();

  cb_result_serializer #(.W(4), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .Arithmetic(res[0]), .Shift(res[1]), .Relational(res[2]),
    .Equality(res[3]), .Bitwise(res[4]), .Reduction(res[5]),
    .Logical(res[6]), .Concatenation(res[7]), .Conditional(res[8]),
    .bus(bus.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, start, ready;
    logic [3:0] fill;
    logic valid;
    logic [3:0] idx, data;
    logic last, busy, done;
  } vec_t;
  vec_t tbl [0:12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // fill==0 selects the ramp 1..9 across slots 0..8, otherwise every slot gets fill
  task automatic set_in(input logic [3:0] f);
    for (int i = 0; i < 9; i++) res[i] = (f == 4'h0) ? 4'(i + 1) : f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string t, input logic v, input logic [3:0] i, input logic [3:0] d,
                      input logic l, input logic b, input logic dn, input logic cd);
    chk({t, " valid"}, 32'(bus.out_valid), 32'(v));
    chk({t, " idx"}, 32'(bus.out_idx), 32'(i));
    chk({t, " last"}, 32'(bus.out_last), 32'(l));
    chk({t, " busy"}, 32'(busy), 32'(b));
    chk({t, " done"}, 32'(done), 32'(dn));
    if (cd) chk({t, " data"}, 32'(bus.out_data), 32'(d));
  endtask

  initial begin
    bus.out_ready = 1'b1;
    set_in(4'h0);
    tbl[0] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0};
    for (int k = 1; k <= 8; k++)
      tbl[2 + k] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 4'(k), 4'(k + 1), k == 8, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    // reset, full stream at ready=1, and inputs forced to F right after capture
    for (int n = 0; n < 13; n++) begin
      rst_n = tbl[n].rst_n;
      start = tbl[n].start;
      bus.out_ready = tbl[n].ready;
      set_in(tbl[n].fill);
      tick();
      beat($sformatf("v%0d", n), tbl[n].valid, tbl[n].idx, tbl[n].data, tbl[n].last,
           tbl[n].busy, tbl[n].done, tbl[n].valid || !tbl[n].rst_n);
    end

    // backpressure at idx 4
    set_in(4'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    beat("bp0", 1'b1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) tick();
    beat("bp4", 1'b1, 4'd4, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      beat($sformatf("bp_hold%0d", k), 1'b1, 4'd4, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    bus.out_ready = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      tick();
      beat($sformatf("bp%0d", k), 1'b1, 4'(k), 4'(k + 1), k == 8, 1'b1, 1'b0, 1'b1);
    end
    tick();
    beat("bp_done", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    beat("bp_idle", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start during SEND is ignored
    set_in(4'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    beat("ss2", 1'b1, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    set_in(4'hA);
    start = 1'b1;
    tick();
    start = 1'b0;
    beat("ss3", 1'b1, 4'd3, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 4; k <= 8; k++) begin
      tick();
      beat($sformatf("ss%0d", k), 1'b1, 4'(k), 4'(k + 1), k == 8, 1'b1, 1'b0, 1'b1);
    end
    tick();
    beat("ss_done", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    beat("ss_idle", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset at idx 6 abandons the frame, then a fresh frame of C
    set_in(4'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    beat("rs6", 1'b1, 4'd6, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    beat("rs_rst", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();
    beat("rs_after", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(4'hC);
    start = 1'b1;
    tick();
    start = 1'b0;
    beat("rc0", 1'b1, 4'd0, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      beat($sformatf("rc%0d", k), 1'b1, 4'(k), 4'hC, k == 8, 1'b1, 1'b0, 1'b1);
    end
    tick();
    beat("rc_done", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
